// File: rtl/nms_stream.sv
// Streaming non-maximum suppression: thins a raster stream of gradient magnitudes along their
// quantised direction. Optional low threshold (port lo_thresh) is enabled by `define NMS_THRESH_EN.
module nms_stream #(
  parameter int unsigned PRECISION  = 8,
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 64
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [PRECISION-1:0] in_mag,
  input  logic [1:0]           in_angle,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [PRECISION-1:0] out_mag,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef NMS_THRESH_EN
  ,
  input  logic [PRECISION-1:0] lo_thresh
`endif
);

  localparam int unsigned Depth = 2 * IMG_WIDTH + 3;
  localparam int unsigned EntW  = PRECISION + 2;
  localparam int unsigned NPix  = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned CntW  = $clog2(NPix);
  localparam int unsigned ColW  = $clog2(IMG_WIDTH);
  localparam int unsigned RowW  = $clog2(IMG_HEIGHT);
  localparam int unsigned FlW   = $clog2(IMG_WIDTH + 1);

  localparam int unsigned TapC  = IMG_WIDTH + 1;
  localparam int unsigned TapW  = IMG_WIDTH + 2;
  localparam int unsigned TapE  = IMG_WIDTH;
  localparam int unsigned TapN  = 2 * IMG_WIDTH + 1;
  localparam int unsigned TapS  = 1;
  localparam int unsigned TapNw = 2 * IMG_WIDTH + 2;
  localparam int unsigned TapNe = 2 * IMG_WIDTH;
  localparam int unsigned TapSw = 2;
  localparam int unsigned TapSe = 0;

  typedef enum logic [1:0] {StIdle, StFill, StRun, StFlush} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        pix_cnt_q;
  logic [FlW-1:0]         flush_cnt_q;
  logic [RowW-1:0]        row_q;
  logic [ColW-1:0]        col_q;
  logic [EntW-1:0]        sr_q [Depth];
  logic [EntW-1:0]        sr_d [Depth];
  logic                   out_valid_q;
  logic [PRECISION-1:0]   out_mag_q;

  logic                   slot_free;
  logic                   accept;
  logic                   advance;
  logic                   produce;
  logic [PRECISION-1:0]   c_mag;
  logic [1:0]             c_ang;
  logic [PRECISION-1:0]   nb_a;
  logic [PRECISION-1:0]   nb_b;
  logic                   border;
  logic                   keep;
  logic [PRECISION-1:0]   result;

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    in_ready  = (state_q != StFlush) && slot_free;
    accept    = in_valid && in_ready;
    advance   = accept || ((state_q == StFlush) && slot_free);
    produce   = advance && ((state_q == StRun) || (state_q == StFlush));
  end

  // Post-shift view: the output for a centre is decided on the edge that brings in its SE pixel.
  always_comb begin
    sr_d[0] = (state_q == StFlush) ? '0 : {in_angle, in_mag};
    for (int i = 1; i < Depth; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_comb begin
    c_mag = sr_d[TapC][PRECISION-1:0];
    c_ang = sr_d[TapC][EntW-1:PRECISION];
    nb_a  = '0;
    nb_b  = '0;
    unique case (c_ang)
      2'd0: begin
        nb_a = sr_d[TapW][PRECISION-1:0];
        nb_b = sr_d[TapE][PRECISION-1:0];
      end
      2'd1: begin
        nb_a = sr_d[TapNe][PRECISION-1:0];
        nb_b = sr_d[TapSw][PRECISION-1:0];
      end
      2'd2: begin
        nb_a = sr_d[TapN][PRECISION-1:0];
        nb_b = sr_d[TapS][PRECISION-1:0];
      end
      2'd3: begin
        nb_a = sr_d[TapNw][PRECISION-1:0];
        nb_b = sr_d[TapSe][PRECISION-1:0];
      end
      default: ;
    endcase
    border = (row_q == '0) || (row_q == RowW'(IMG_HEIGHT - 1)) ||
             (col_q == '0) || (col_q == ColW'(IMG_WIDTH - 1));
    keep   = (c_mag >= nb_a) && (c_mag >= nb_b);
`ifdef NMS_THRESH_EN
    keep   = keep && (c_mag >= lo_thresh);
`endif
    result = (border || !keep) ? '0 : c_mag;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      pix_cnt_q   <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_mag_q   <= '0;
      for (int i = 0; i < Depth; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      if (advance) begin
        for (int i = 0; i < Depth; i++) begin
          sr_q[i] <= sr_d[i];
        end
      end

      if (produce) begin
        out_valid_q <= 1'b1;
        out_mag_q   <= result;
        if (col_q == ColW'(IMG_WIDTH - 1)) begin
          col_q <= '0;
          row_q <= (row_q == RowW'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: if (accept) begin
          pix_cnt_q <= CntW'(1);
          state_q   <= StFill;
        end
        StFill: if (accept) begin
          pix_cnt_q <= pix_cnt_q + 1'b1;
          if (pix_cnt_q == CntW'(IMG_WIDTH)) state_q <= StRun;
        end
        StRun: if (accept) begin
          if (pix_cnt_q == CntW'(NPix - 1)) begin
            pix_cnt_q   <= '0;
            flush_cnt_q <= '0;
            state_q     <= StFlush;
          end else begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
          end
        end
        StFlush: if (slot_free) begin
          if (flush_cnt_q == FlW'(IMG_WIDTH)) begin
            flush_cnt_q <= '0;
            state_q     <= StIdle;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_mag   = out_mag_q;

endmodule

// File: tb/tb_nms_stream.sv
// Self-checking bench for nms_stream (4x4 frames) against a 2-D coordinate reference model.
module tb_nms_stream;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int MAXF = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] in_mag = '0;
  logic [1:0] in_angle = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_mag;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] lo_thr = '0;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] fm [NPIX*MAXF];
  logic [1:0] fa [NPIX*MAXF];
  logic [7:0] got [$];
  logic [7:0] saved [$];
  int stall_cnt;
  int flush_low;

  nms_stream #(
    .PRECISION (8),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .in_mag   (in_mag),
    .in_angle (in_angle),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_mag  (out_mag),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef NMS_THRESH_EN
    ,
    .lo_thresh(lo_thr)
`endif
  );

  always #5 clk = ~clk;

  // Reference: pixel (r,c) of frame f, from 2-D neighbourhood rules.
  function automatic logic [7:0] ref_pix(input int f, input int r, input int c);
    int base, dr, dc;
    logic [7:0] m, a, b;
    base = f * NPIX;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
    m = fm[base + r*W + c];
    case (fa[base + r*W + c])
      2'd0:    begin dr = 0;  dc = 1; end
      2'd1:    begin dr = -1; dc = 1; end
      2'd2:    begin dr = 1;  dc = 0; end
      default: begin dr = 1;  dc = 1; end
    endcase
    a = fm[base + (r+dr)*W + (c+dc)];
    b = fm[base + (r-dr)*W + (c-dc)];
    if (m < a || m < b) return 8'd0;
    if (m < lo_thr) return 8'd0;
    return m;
  endfunction

  task automatic fill_const(input int f, input logic [7:0] m, input logic [1:0] a);
    for (int i = 0; i < NPIX; i++) begin
      fm[f*NPIX + i] = m;
      fa[f*NPIX + i] = a;
    end
  endtask

  task automatic fill_rand(input int f);
    for (int i = 0; i < NPIX; i++) begin
      fm[f*NPIX + i] = 8'($urandom_range(0, 7));
      fa[f*NPIX + i] = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int n_in, input int want_out, input bit rand_gap,
                           input bit rand_bp, input int stall_at, input int stall_len);
    int idx = 0;
    int cyc = 0;
    logic [7:0] held = '0;
    bit acc;
    got.delete();
    stall_cnt = 0;
    flush_low = 0;
    while ((idx < n_in || got.size() < want_out) && cyc < 3000) begin
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len) &&
                  (!rand_bp || $urandom_range(0, 3) != 0);
      in_valid = (idx < n_in) && (!rand_gap || $urandom_range(0, 3) != 0);
      if (idx < n_in) begin
        in_mag = fm[idx];
        in_angle = fa[idx];
      end
      @(negedge clk);
      if (out_valid && out_ready) got.push_back(out_mag);
      acc = in_valid && in_ready;
      if (idx < n_in && in_valid && !in_ready) stall_cnt++;
      if (idx == n_in && !in_ready) flush_low++;
      if (stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len) begin
        if (cyc == stall_at) held = out_mag;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_mag !== held) begin
          miscompares++;
          $display("FAIL stall_hold cyc %0d: in_ready=%b out_valid=%b out_mag=%0d, required 0/1/%0d",
                   cyc, in_ready, out_valid, out_mag, held);
        end
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (cyc >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: accepted %0d of %0d, outputs %0d of %0d", idx, n_in, got.size(),
               want_out);
    end
  endtask

  task automatic check_outputs(input string name, input int nfr);
    int i;
    vectors++;
    if (got.size() != nfr * NPIX) begin
      miscompares++;
      $display("FAIL %s count: got %0d outputs, required %0d", name, got.size(), nfr * NPIX);
    end
    for (int f = 0; f < nfr; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          i = f*NPIX + r*W + c;
          if (i < got.size()) begin
            vectors++;
            if (got[i] !== ref_pix(f, r, c)) begin
              miscompares++;
              $display("FAIL %s f%0d (%0d,%0d): got %0d, required %0d", name, f, r, c, got[i],
                       ref_pix(f, r, c));
            end
          end
        end
  endtask

  task automatic expect_pix(input string name, input int i, input logic [7:0] exp);
    vectors++;
    if (i >= got.size() || got[i] !== exp) begin
      miscompares++;
      $display("FAIL %s idx %0d: got %0d, required %0d", name, i,
               (i < got.size()) ? got[i] : 8'hxx, exp);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_mag !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_hold: out_valid=%b out_mag=%0d, required 0/0", out_valid, out_mag);
    end
    @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_mag !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b out_mag=%0d, required 1/0/0",
               in_ready, out_valid, out_mag);
    end
    @(posedge clk);
    #1;
    fill_const(0, 8'd5, 2'd0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_mag = fm[i];
      in_angle = fa[i];
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL fill_no_output pix %0d: out_valid=%b in_ready=%b, required 0/1", i,
                 out_valid, in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_mag !== 8'd0) begin
      miscompares++;
      $display("FAIL first_output: out_valid=%b out_mag=%0d, required 1/0", out_valid, out_mag);
    end
    do_reset();
  endtask

  task automatic test_flat();
    fill_const(0, 8'd5, 2'd0);
    run_frame(NPIX, NPIX, 1'b0, 1'b0, 0, 0);
    check_outputs("flat", 1);
    expect_pix("flat_border", 0, 8'd0);
    expect_pix("flat_interior", 5, 8'd5);
    expect_pix("flat_interior", 10, 8'd5);
    vectors++;
    if (flush_low != W + 1) begin
      miscompares++;
      $display("FAIL flush_cycles: in_ready low %0d cycles, required %0d", flush_low, W + 1);
    end
  endtask

  task automatic test_peak();
    fill_const(0, 8'd3, 2'd0);
    fm[5] = 8'd9;
    run_frame(NPIX, NPIX, 1'b0, 1'b0, 0, 0);
    check_outputs("peak", 1);
    expect_pix("peak_max", 5, 8'd9);
    expect_pix("peak_beside", 6, 8'd0);
    expect_pix("peak_tie", 9, 8'd3);
    expect_pix("peak_tie", 10, 8'd3);
  endtask

  task automatic test_direction();
    for (int ang = 0; ang < 2; ang++) begin
      fill_const(0, 8'd0, 2'd0);
      fm[5] = 8'd6;
      fm[1] = 8'd7;
      fm[9] = 8'd1;
      fm[4] = 8'd2;
      fm[6] = 8'd2;
      fa[5] = (ang == 0) ? 2'd2 : 2'd0;
      run_frame(NPIX, NPIX, 1'b0, 1'b0, 0, 0);
      check_outputs("direction", 1);
      expect_pix("direction_sel", 5, (ang == 0) ? 8'd0 : 8'd6);
    end
  endtask

  task automatic test_backpressure();
    fill_rand(0);
    run_frame(NPIX, NPIX, 1'b0, 1'b0, 0, 0);
    saved = got;
    run_frame(NPIX, NPIX, 1'b0, 1'b0, 10, 5);
    check_outputs("backpressure", 1);
    vectors++;
    if (got != saved) begin
      miscompares++;
      $display("FAIL stall_vs_nostall: sequences differ (%0d vs %0d outputs)", got.size(),
               saved.size());
    end
  endtask

  task automatic test_back_to_back();
    fill_const(0, 8'd5, 2'd0);
    fill_rand(1);
    run_frame(2*NPIX, 2*NPIX, 1'b0, 1'b0, 0, 0);
    check_outputs("back_to_back", 2);
    vectors++;
    if (stall_cnt != W + 1) begin
      miscompares++;
      $display("FAIL frame_gap: input blocked %0d cycles, required %0d", stall_cnt, W + 1);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int f = 0; f < 3; f++) fill_rand(f);
      run_frame(3*NPIX, 3*NPIX, 1'b1, 1'b1, 0, 0);
      check_outputs("random", 3);
    end
  endtask

  task automatic test_reset_mid();
    fill_rand(0);
    run_frame(9, 0, 1'b0, 1'b0, 0, 0);
    do_reset();
    fill_const(0, 8'd5, 2'd0);
    run_frame(NPIX, NPIX, 1'b0, 1'b0, 0, 0);
    check_outputs("reset_mid", 1);
    expect_pix("reset_mid_interior", 6, 8'd5);
  endtask

`ifdef NMS_THRESH_EN
  task automatic test_thresh();
    lo_thr = 8'd6;
    fill_const(0, 8'd5, 2'd0);
    run_frame(NPIX, NPIX, 1'b0, 1'b0, 0, 0);
    check_outputs("thresh_flat", 1);
    expect_pix("thresh_below", 5, 8'd0);
    lo_thr = 8'd5;
    run_frame(NPIX, NPIX, 1'b0, 1'b0, 0, 0);
    check_outputs("thresh_equal", 1);
    expect_pix("thresh_equal", 5, 8'd5);
    lo_thr = 8'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_flat();
    test_peak();
    test_direction();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef NMS_THRESH_EN
    test_thresh();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nms_stream.md
Name: nms_stream

Overview:
- Streaming non-maximum suppression stage of the edge-detection pipeline.
- Sits directly downstream of the gradient magnitude/angle unit and consumes its per-pixel output.
- Takes a raster-order stream of (magnitude, quantised angle) pairs over a valid/ready handshake and buffers two image rows plus three pixels.
- Emits one thinned magnitude per input pixel, in the same raster order: each pixel is kept only if it is a local maximum along its gradient direction, otherwise it is forced to zero.

Parameters:
PRECISION, 8, magnitude width in bits (matches the gradient unit's output precision)
IMG_WIDTH, 64, pixels per row; legal range is 3 or more
IMG_HEIGHT, 64, rows per frame; legal range is 2 or more

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
in_mag  input  PRECISION  gradient magnitude, unsigned
in_angle  input  2  quantised direction: 0 = W/E neighbours, 1 = NE/SW, 2 = N/S, 3 = NW/SE
in_valid  input  1  input pixel valid
in_ready  output  1  block can accept a pixel this cycle
out_mag  output  PRECISION  suppressed magnitude
out_valid  output  1  out_mag valid
out_ready  input  1  downstream accepts out_mag

Behaviour:
- Reset (asynchronous, n_rst low): state = IDLE; all counters = 0; shift register cleared to 0; out_valid = 0; out_mag = 0. After release, in_ready = 1.
- Storage is a shift register of 2*IMG_WIDTH+3 entries, each {angle, mag}. Entry 0 is the newest.
- Taps:
  - centre = IMG_WIDTH+1
  - W = IMG_WIDTH+2, E = IMG_WIDTH
  - N = 2*IMG_WIDTH+1, S = 1
  - NW = 2*IMG_WIDTH+2, NE = 2*IMG_WIDTH
  - SW = 2, SE = 0
- Output slot is free when out_valid = 0 or out_ready = 1.
- in_ready = (state != FLUSH) and slot free.
- Advance condition: an input is accepted (in_valid and in_ready), or state = FLUSH and the slot is free. On an advance the register shifts by one. In FLUSH, {0,0} is shifted in.
- States:
  - IDLE: waiting for the first pixel of a frame. First accept moves to FILL.
  - FILL: first IMG_WIDTH+1 accepts (pixel indices 0..IMG_WIDTH). No output is produced. The accept of index IMG_WIDTH moves to RUN.
  - RUN: each accept produces one output.
  - FLUSH: entered after the accept of index IMG_WIDTH*IMG_HEIGHT-1. Performs IMG_WIDTH+1 advances, each producing one output, then returns to IDLE.
- Output count: exactly IMG_WIDTH*IMG_HEIGHT outputs per frame, in raster order.
- Output timing: on an advance that produces an output, out_valid = 1 and out_mag are registered; they appear on the next cycle. Latency from accepting pixel k+IMG_WIDTH+1 to out_valid for centre k is 1 cycle.
- out_valid clears when the output is taken (out_ready = 1) and no new output is produced in the same cycle.
- out_mag is held stable while out_valid = 1 and out_ready = 0.
- Centre position: separate centre row/column counters track the position of the centre pixel, and wrap at the end of each row and frame.
- Border: if the centre is in row 0, row IMG_HEIGHT-1, column 0 or column IMG_WIDTH-1, out_mag = 0. Tap values that wrap across rows are therefore irrelevant.
- Interior: select the neighbour pair (a, b) by the centre's angle. Keep the magnitude iff centre >= a and centre >= b. Ties are kept, and a centre magnitude of 0 gives 0. Comparisons are unsigned, PRECISION bits, with no arithmetic widening.
- Simultaneous events:
  - Take and produce in the same cycle: out_valid stays 1 with the new value.
  - The last input accept and the FLUSH entry happen on the same edge, and in_ready drops in the following cycle.
  - The next frame's first pixel is accepted in the cycle after FLUSH completes.
- Reset mid-frame: partial-frame state is discarded and the next accepted pixel is index 0 of a new frame.

Optional Feature:
NMS_THRESH_EN
- Defined: adds input port lo_thresh (PRECISION bits, quasi-static, sampled every output). Any kept interior magnitude below lo_thresh is output as 0. Magnitudes equal to lo_thresh are kept.
- Undefined: the port is absent and there is no thresholding. Behaviour is exactly as described above.

Test Plan:
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4 unless stated.
- Reset: hold n_rst low, then release -> out_valid=0, out_mag=0, in_ready=1; no output until 6 pixels accepted.
- Flat frame: all mag=5, angle 0, out_ready=1 -> 16 outputs; border positions 0 and (1,1),(1,2),(2,1),(2,2) = 5; in_ready low for exactly 5 flush cycles.
- Peak: mag=3 everywhere except (1,1)=9, angle 0 -> (1,1)=9, (1,2)=0, (2,1)=3, (2,2)=3.
- Direction select: centre (1,1)=6 with N=7, S=1, W=E=2. Angle 2 -> 0. Angle 0 -> 6.
- Backpressure: out_ready low for 5 cycles mid-RUN -> in_ready=0, out_mag held; output sequence identical to the no-stall run, with none lost or duplicated.
- Reset at pixel 9, then a full flat frame -> exactly 16 outputs matching the flat-frame result. With NMS_THRESH_EN and lo_thresh=6, the flat frame gives all 0.
